// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute sequencer for the 8-bit model CPU (IR, phase bit, one-hot
// instruction lines, Z/C flags, halt/illegal/bus-error status). Optional macro SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] ram_dout,
  input  logic       ram_ready,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       cf_en,
  input  logic       zf_en,
  output logic       sm,
  output logic [7:0] ir,
  output logic       mova,
  output logic       movb,
  output logic       movc,
  output logic       add,
  output logic       sub,
  output logic       and1,
  output logic       not1,
  output logic       rsr,
  output logic       rsl,
  output logic       jmp,
  output logic       jz,
  output logic       jc,
  output logic       in1,
  output logic       out1,
  output logic       nop,
  output logic       halt,
  output logic       z,
  output logic       c,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam int L_NOP  = 0;
  localparam int L_HALT = 1;
  localparam int L_IN1  = 2;
  localparam int L_OUT1 = 3;
  localparam int L_MOVA = 4;
  localparam int L_MOVB = 5;
  localparam int L_MOVC = 6;
  localparam int L_ADD  = 7;
  localparam int L_SUB  = 8;
  localparam int L_RSR  = 9;
  localparam int L_RSL  = 10;
  localparam int L_AND1 = 11;
  localparam int L_NOT1 = 12;
  localparam int L_JMP  = 13;
  localparam int L_JZ   = 14;
  localparam int L_JC   = 15;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sm_q, sm_d;
  logic [7:0]         ir_q, ir_d;
  logic [15:0]        lines_q, lines_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  logic               start_req;
  logic               is_mem;
  logic               waiting;
  logic               timeout_hit;
  logic               exec_done;
  logic [16:0]        dec;

  // Returns {undefined_opcode, one-hot line vector}; undefined opcodes decode as nop.
  function automatic logic [16:0] decode(input logic [7:0] op);
    logic [15:0] l;
    logic        bad;
    l   = '0;
    bad = 1'b0;
    case (op[7:4])
      4'h0: l[L_NOP]  = 1'b1;
      4'h1: l[L_HALT] = 1'b1;
      4'h4: l[L_IN1]  = 1'b1;
      4'h5: l[L_OUT1] = 1'b1;
      4'h7: begin
        if (op[3:2] == 2'b11)      l[L_MOVB] = 1'b1;
        else if (op[1:0] == 2'b11) l[L_MOVC] = 1'b1;
        else                       l[L_MOVA] = 1'b1;
      end
      4'h8: l[L_ADD]  = 1'b1;
      4'h9: l[L_SUB]  = 1'b1;
      4'hA: l[L_RSR]  = 1'b1;
      4'hB: l[L_RSL]  = 1'b1;
      4'hC: l[L_AND1] = 1'b1;
      4'hD: l[L_NOT1] = 1'b1;
      4'hE: l[L_JMP]  = 1'b1;
      4'hF: begin
        case (op[3:2])
          2'b00:   l[L_JZ] = 1'b1;
          2'b01:   l[L_JC] = 1'b1;
          default: begin
            l[L_NOP] = 1'b1;
            bad      = 1'b1;
          end
        endcase
      end
      default: begin
        l[L_NOP] = 1'b1;
        bad      = 1'b1;
      end
    endcase
    return {bad, l};
  endfunction

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  // A held step produces a single rise, so it can only launch one instruction.
  assign step_rise = step & ~step_q;
  assign start_req = run | step_rise;
`else
  assign start_req = run;
`endif

  assign dec         = decode(ram_dout);
  assign is_mem      = lines_q[L_MOVB] | lines_q[L_MOVC] | lines_q[L_IN1] | lines_q[L_OUT1];
  assign waiting     = ((state_q == S_FETCH) && !ram_ready) ||
                       ((state_q == S_EXEC) && is_mem && !ram_ready);
  assign timeout_hit = waiting && (cnt_q == CNT_W'(WAIT_MAX - 1));
  assign exec_done   = (state_q == S_EXEC) && (!is_mem || ram_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_req) state_d = S_FETCH;
      S_FETCH: begin
        if (ram_ready)        state_d = S_EXEC;
        else if (timeout_hit) state_d = S_HALTED;
      end
      S_EXEC: begin
        if (timeout_hit)           state_d = S_HALTED;
        else if (exec_done) begin
          if (lines_q[L_HALT])     state_d = S_HALTED;
          else if (run)            state_d = S_FETCH;
          else                     state_d = S_IDLE;
        end
      end
      default:                     state_d = S_HALTED;
    endcase
  end

  always_comb begin
    cnt_d     = '0;
    sm_d      = (state_d == S_EXEC);
    ir_d      = ir_q;
    lines_d   = '0;
    z_d       = z_q;
    c_d       = c_q;
    halted_d  = (state_d == S_HALTED);
    illegal_d = illegal_q;
    bus_err_d = bus_err_q | timeout_hit;

    // The counter restarts on every state change and only runs while a RAM access is pending.
    if ((state_d == state_q) && waiting)
      cnt_d = cnt_q + 1'b1;

    if ((state_q == S_FETCH) && ram_ready) begin
      ir_d      = ram_dout;
      illegal_d = illegal_q | dec[16];
    end

    case (state_d)
      S_EXEC:   lines_d = (state_q == S_FETCH) ? dec[15:0] : lines_q;
      S_HALTED: lines_d[L_HALT] = 1'b1;
      default:  lines_d = '0;
    endcase

    if (exec_done) begin
      if (cf_en) c_d = alu_c;
      if (zf_en) z_d = alu_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      sm_q      <= 1'b0;
      ir_q      <= 8'h00;
      lines_q   <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sm_q      <= sm_d;
      ir_q      <= ir_d;
      lines_q   <= lines_d;
      z_q       <= z_d;
      c_q       <= c_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign sm      = sm_q;
  assign ir      = ir_q;
  assign z       = z_q;
  assign c       = c_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  assign nop  = lines_q[L_NOP];
  assign halt = lines_q[L_HALT];
  assign in1  = lines_q[L_IN1];
  assign out1 = lines_q[L_OUT1];
  assign mova = lines_q[L_MOVA];
  assign movb = lines_q[L_MOVB];
  assign movc = lines_q[L_MOVC];
  assign add  = lines_q[L_ADD];
  assign sub  = lines_q[L_SUB];
  assign rsr  = lines_q[L_RSR];
  assign rsl  = lines_q[L_RSL];
  assign and1 = lines_q[L_AND1];
  assign not1 = lines_q[L_NOT1];
  assign jmp  = lines_q[L_JMP];
  assign jz   = lines_q[L_JZ];
  assign jc   = lines_q[L_JC];

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scenario tasks plus a randomized instruction stream checked against a
// per-instruction reference model (decode table, wait counts, flag rules).
module tb_instr_sequencer;

  localparam int I_NOP = 0, I_HALT = 1, I_IN1 = 2, I_OUT1 = 3, I_MOVA = 4, I_MOVB = 5,
                 I_MOVC = 6, I_ADD = 7, I_SUB = 8, I_RSR = 9, I_RSL = 10, I_AND1 = 11,
                 I_NOT1 = 12, I_JMP = 13, I_JZ = 14, I_JC = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_ready = 1'b0;
  logic       alu_c = 1'b0, alu_z = 1'b0, cf_en = 1'b0, zf_en = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif
  logic       sm;
  logic [7:0] ir;
  logic mova, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt;
  logic z, c, halted, illegal, bus_err;
  logic [15:0] lines;

  int total = 0;
  int bad = 0;
  bit z_m, c_m, ill_m, berr_m;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .ram_dout(ram_dout), .ram_ready(ram_ready),
    .alu_c(alu_c), .alu_z(alu_z), .cf_en(cf_en), .zf_en(zf_en),
    .sm(sm), .ir(ir),
    .mova(mova), .movb(movb), .movc(movc), .add(add), .sub(sub), .and1(and1), .not1(not1),
    .rsr(rsr), .rsl(rsl), .jmp(jmp), .jz(jz), .jc(jc), .in1(in1), .out1(out1), .nop(nop),
    .halt(halt),
    .z(z), .c(c), .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  assign lines = {jc, jz, jmp, not1, and1, rsl, rsr, sub, add, movc, movb, mova, out1, in1, halt, nop};

  function automatic logic [21:0] dut_vec();
    return {sm, halted, bus_err, illegal, z, c, lines};
  endfunction

  function automatic logic [21:0] mdl_vec(input bit s, input bit h, input logic [15:0] l);
    return {s, h, berr_m, ill_m, z_m, c_m, l};
  endfunction

  // Opcode table of the model CPU: which line, whether undefined, whether it waits on RAM.
  function automatic void ref_decode(input logic [7:0] op, output int li, output bit ill, output bit mem);
    logic [3:0] hi;
    hi  = op[7:4];
    ill = 1'b0;
    case (hi)
      4'h0: li = I_NOP;   4'h1: li = I_HALT;  4'h4: li = I_IN1;   4'h5: li = I_OUT1;
      4'h8: li = I_ADD;   4'h9: li = I_SUB;   4'hA: li = I_RSR;   4'hB: li = I_RSL;
      4'hC: li = I_AND1;  4'hD: li = I_NOT1;  4'hE: li = I_JMP;
      4'h7: li = (op[3:2] == 2'b11) ? I_MOVB : ((op[1:0] == 2'b11) ? I_MOVC : I_MOVA);
      4'hF: begin
        if (op[3:2] == 2'b00)      li = I_JZ;
        else if (op[3:2] == 2'b01) li = I_JC;
        else begin li = I_NOP; ill = 1'b1; end
      end
      default: begin li = I_NOP; ill = 1'b1; end
    endcase
    mem = (li == I_MOVB) || (li == I_MOVC) || (li == I_IN1) || (li == I_OUT1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0; ram_ready = 1'b0; cf_en = 1'b0; zf_en = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    z_m = 0; c_m = 0; ill_m = 0; berr_m = 0;
  endtask

  task automatic start_run();
    run = 1'b1; ram_ready = 1'b0;
    tick();
  endtask

  // Runs one instruction starting in FETCH; ends in FETCH (or IDLE if !resume, or HALTED).
  task automatic do_instr(input logic [7:0] op, input int fw, input int ew, input bit ac,
                          input bit az, input bit ce, input bit ze, input bit run_after,
                          input bit resume, input string tag);
    int li; bit ill; bit mem; logic [15:0] el; int ecyc;
    ref_decode(op, li, ill, mem);
    el = 16'h1 << li;
    ecyc = 1;
    for (int i = 0; i < fw; i++) begin
      ram_ready = 1'b0; ram_dout = 8'($urandom);
      tick();
      total++;
      if (dut_vec() !== mdl_vec(0, 0, 16'h0)) begin
        bad++; $display("FAIL %s_fetch_wait: got %h want %h", tag, dut_vec(), mdl_vec(0, 0, 16'h0));
      end
    end
    ram_ready = 1'b1; ram_dout = op;
    tick();
    if (ill) ill_m = 1'b1;
    total++;
    if ({dut_vec(), ir} !== {mdl_vec(1, 0, el), op}) begin
      bad++; $display("FAIL %s_exec_entry: got %h want %h", tag, {dut_vec(), ir}, {mdl_vec(1, 0, el), op});
    end
    if (mem) begin
      for (int i = 0; i < ew; i++) begin
        ram_ready = 1'b0;
        tick();
        ecyc++;
        total++;
        if (dut_vec() !== mdl_vec(1, 0, el)) begin
          bad++; $display("FAIL %s_exec_wait: got %h want %h", tag, dut_vec(), mdl_vec(1, 0, el));
        end
      end
    end
    ram_ready = mem ? 1'b1 : 1'($urandom);
    alu_c = ac; alu_z = az; cf_en = ce; zf_en = ze; run = run_after;
    tick();
    ram_ready = 1'b0; cf_en = 1'b0; zf_en = 1'b0;
    if (ce) c_m = ac;
    if (ze) z_m = az;
    if (li == I_HALT) begin
      total++;
      if (dut_vec() !== mdl_vec(0, 1, 16'h1 << I_HALT)) begin
        bad++; $display("FAIL %s_halt: got %h want %h", tag, dut_vec(), mdl_vec(0, 1, 16'h1 << I_HALT));
      end
    end else begin
      total++;
      if (dut_vec() !== mdl_vec(0, 0, 16'h0)) begin
        bad++; $display("FAIL %s_exit: got %h want %h", tag, dut_vec(), mdl_vec(0, 0, 16'h0));
      end
      if (!run_after) begin
        // In IDLE a ready RAM must not be fetched while run stays low.
        ram_ready = 1'b1; ram_dout = 8'h81;
        tick();
        ram_ready = 1'b0;
        total++;
        if (dut_vec() !== mdl_vec(0, 0, 16'h0)) begin
          bad++; $display("FAIL %s_idle: got %h want %h", tag, dut_vec(), mdl_vec(0, 0, 16'h0));
        end
        if (resume) start_run();
      end
    end
    $display("txn %s op=%02h line=%0d fw=%0d exec_cycles=%0d z=%0b c=%0b ill=%0b", tag, op, li, fw,
             ecyc, z_m, c_m, ill_m);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0;
    #12;
    total++;
    if ({dut_vec(), ir} !== 30'h0) begin
      bad++; $display("FAIL reset_init: got %h want 0", {dut_vec(), ir});
    end
    rst_n = 1'b1;
    z_m = 0; c_m = 0; ill_m = 0; berr_m = 0;
    start_run();
    do_instr(8'h81, 0, 0, 1, 1, 1, 1, 1, 1, "pre_add");
    do_instr(8'h20, 1, 0, 0, 0, 0, 0, 1, 1, "pre_ill");
    ram_ready = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({dut_vec(), ir} !== 30'h0) begin
      bad++; $display("FAIL reset_mid_fetch: got %h want 0", {dut_vec(), ir});
    end
    run = 1'b1; ram_ready = 1'b1; ram_dout = 8'h81;
    tick();
    total++;
    if ({dut_vec(), ir} !== 30'h0) begin
      bad++; $display("FAIL reset_held: got %h want 0", {dut_vec(), ir});
    end
    rst_n = 1'b1; run = 1'b0;
    z_m = 0; c_m = 0; ill_m = 0; berr_m = 0;
    tick(); tick();
    ram_ready = 1'b0;
    total++;
    if ({dut_vec(), ir} !== 30'h0) begin
      bad++; $display("FAIL reset_idle: got %h want 0", {dut_vec(), ir});
    end
  endtask

  task automatic test_add_halt();
    do_reset();
    start_run();
    do_instr(8'h81, 0, 0, 1, 0, 1, 1, 1, 1, "add");
    do_instr(8'h10, 0, 0, 0, 1, 0, 0, 1, 1, "halt");
    for (int i = 0; i < 4; i++) begin
      run = 1'(i); ram_ready = 1'b1;
      tick();
      total++;
      if (dut_vec() !== mdl_vec(0, 1, 16'h1 << I_HALT)) begin
        bad++; $display("FAIL halted_sticky: got %h want %h", dut_vec(), mdl_vec(0, 1, 16'h1 << I_HALT));
      end
    end
  endtask

  task automatic test_movb_wait();
    do_reset();
    start_run();
    do_instr(8'h7C, 1, 3, 0, 0, 0, 0, 1, 1, "movb");
    do_instr(8'h73, 0, 0, 1, 1, 1, 0, 1, 1, "movc");
    do_instr(8'h72, 2, 0, 0, 0, 0, 0, 0, 1, "mova");
  endtask

  task automatic test_jz_illegal();
    do_reset();
    start_run();
    do_instr(8'h90, 0, 0, 0, 1, 0, 1, 1, 1, "setz");
    do_instr(8'hF0, 0, 0, 1, 0, 1, 0, 1, 1, "jz");
    do_instr(8'hF5, 0, 0, 0, 0, 0, 0, 1, 1, "jc");
    do_instr(8'h20, 0, 0, 0, 0, 0, 0, 1, 1, "op20");
    do_instr(8'hFA, 0, 0, 0, 0, 0, 0, 1, 1, "opFA");
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    start_run();
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if (dut_vec() !== mdl_vec(0, 0, 16'h0)) begin
        bad++; $display("FAIL fetch_to_wait%0d: got %h want %h", i, dut_vec(), mdl_vec(0, 0, 16'h0));
      end
    end
    tick();
    berr_m = 1'b1;
    total++;
    if (dut_vec() !== mdl_vec(0, 1, 16'h1 << I_HALT)) begin
      bad++; $display("FAIL fetch_timeout: got %h want %h", dut_vec(), mdl_vec(0, 1, 16'h1 << I_HALT));
    end
    $display("txn fetch_timeout bus_err=%0b halted=%0b", bus_err, halted);
    do_reset();
    start_run();
    do_instr(8'h90, 15, 0, 1, 0, 1, 1, 1, 1, "fetch_last_ready");
    do_instr(8'h43, 0, 15, 0, 0, 0, 0, 1, 1, "exec_last_ready");
  endtask

  task automatic test_exec_timeout();
    do_reset();
    start_run();
    ram_ready = 1'b1; ram_dout = 8'h50;
    tick();
    ram_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if (dut_vec() !== mdl_vec(1, 0, 16'h1 << I_OUT1)) begin
        bad++; $display("FAIL exec_to_wait%0d: got %h want %h", i, dut_vec(), mdl_vec(1, 0, 16'h1 << I_OUT1));
      end
    end
    tick();
    berr_m = 1'b1;
    total++;
    if (dut_vec() !== mdl_vec(0, 1, 16'h1 << I_HALT)) begin
      bad++; $display("FAIL exec_timeout: got %h want %h", dut_vec(), mdl_vec(0, 1, 16'h1 << I_HALT));
    end
    $display("txn exec_timeout bus_err=%0b halted=%0b", bus_err, halted);
  endtask

  task automatic test_random();
    logic [7:0] op; int fw, ew;
    do_reset();
    start_run();
    for (int n = 0; n < 80; n++) begin
      op = 8'($urandom);
      fw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      ew = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      do_instr(op, fw, ew, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3) != 0, 1, "rand");
      if (op[7:4] == 4'h1) begin
        do_reset();
        start_run();
      end
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    tick();
    step = 1'b1;
    tick();
    do_instr(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, "step_nop");
    for (int i = 0; i < 10; i++) begin
      ram_ready = 1'b1; ram_dout = 8'h00;
      tick();
      total++;
      if (dut_vec() !== mdl_vec(0, 0, 16'h0)) begin
        bad++; $display("FAIL step_held%0d: got %h want %h", i, dut_vec(), mdl_vec(0, 0, 16'h0));
      end
    end
    ram_ready = 1'b0;
    step = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add_halt();
    test_movb_wait();
    test_jz_illegal();
    test_fetch_timeout();
    test_exec_timeout();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
